cam_capture_ctrl: RTL

Frame-capture controller for the OV7670 path, clocked by the camera pixel clock. It tracks VSYNC/HREF, pairs the two RGB565 bytes of each pixel, and converts them to RGB332. It writes each pixel into the frame buffer at a linear address, clipped to a fixed window. It sequences single-shot or continuous captures and reports completion to the display/control side.

---
 rtl/cam_capture_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cam_capture_ctrl.sv
`timescale 1ns/1ps
// cam_capture_ctrl: OV7670 frame-capture controller in the pixel-clock domain.
// It pairs RGB565 bytes into RGB332 pixels and writes them to a linear
// frame buffer that is clipped to an H_PIXELS x V_LINES window. It also
// sequences single-shot or continuous captures.
module cam_capture_ctrl #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int AW       = 15
) (
  input  logic          pclk,
  input  logic          in_reset,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          capture_req,
  input  logic          continuous,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_wr,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    line_cnt
);

  localparam int              CW     = $clog2(H_PIXELS + 1);
  localparam logic [CW-1:0]   H_MAX  = CW'(H_PIXELS);
  localparam logic [7:0]      V_MAX  = 8'(V_LINES);
  localparam logic [AW-1:0]   H_STEP = AW'(H_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          vs_q, hr_q;
  logic          phase_q, phase_d;
  logic [5:0]    byte0_q, byte0_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    line_q, line_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          mem_wr_q, mem_wr_d;

  logic          vs_rise, vs_fall, hr_fall;

  // RGB332 from the kept bits of the first byte (R[4:2], G[5:3]) and the
  // two blue MSBs carried in the second byte.
  function automatic logic [7:0] rgb565_to_332(input logic [5:0] hi_bits,
                                               input logic [1:0] blue_msb);
    return {hi_bits, blue_msb};
  endfunction

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;
  assign hr_fall = hr_q & ~href;

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign frame_done = (state_q == S_DONE);
  assign line_cnt   = line_q;

  // Next-state, byte pairing, window clipping and line bookkeeping.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    byte0_d    = byte0_q;
    col_d      = col_q;
    line_d     = line_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wr_d   = 1'b0;

    // A line boundary always restarts byte pairing, so a trailing odd
    // byte is discarded.
    if (!href) begin
      phase_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (capture_req) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!capture_req) begin
          state_d = S_IDLE;
        end else if (vs_fall) begin
          col_d   = '0;
          line_d  = '0;
          base_d  = '0;
          phase_d = 1'b0;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            byte0_d = {px_data[7:5], px_data[2:0]};
          end else if ((col_q < H_MAX) && (line_q < V_MAX)) begin
            mem_wr_d   = 1'b1;
            mem_addr_d = base_q + AW'(col_q);
            mem_data_d = rgb565_to_332(byte0_q, px_data[4:3]);
            col_d      = col_q + 1'b1;
          end
        end else if (hr_fall && (col_q != '0)) begin
          line_d = line_q + 8'd1;
          base_d = base_q + H_STEP;
          col_d  = '0;
        end
        // capture_req is ignored here; a started frame always completes.
        if (vs_rise || (line_q == V_MAX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A vsync fall seen in this cycle is deliberately not acted on.
        state_d = (continuous && capture_req) ? S_ARM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge pclk or negedge in_reset) begin
    if (!in_reset) begin
      state_q    <= S_IDLE;
      vs_q       <= 1'b0;
      hr_q       <= 1'b0;
      phase_q    <= 1'b0;
      col_q      <= '0;
      line_q     <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vsync;
      hr_q       <= href;
      phase_q    <= phase_d;
      col_q      <= col_d;
      line_q     <= line_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  // First-byte holding register; its content is only consumed after a
  // phase-0 load, so it needs no reset.
  always_ff @(posedge pclk) begin
    byte0_q <= byte0_d;
  end

endmodule
